ysyx_22040759_ifu: RTL and testbench
====================================

# ysyx_22040759_ifu

Instruction fetch unit for the ysyx_22040759 core. It sits directly upstream of the decode/control stage. It owns the architectural PC and fetches 32-bit instructions over a valid/ready request plus valid response memory port. It presents each instruction with its PC to decode through a valid/ready handshake, and applies redirects (jal/jalr targets) coming back from execute.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  64  fetch address, bits [1:0] always 0
- imem_rsp_valid  input  1  response data valid, exactly one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  input  32  fetched instruction word
- inst_valid  output  1  inst_o/pc_o valid toward decode
- inst_ready  input  1  decode consumes instruction
- inst_o  output  32  instruction to decode
- pc_o  output  64  PC of inst_o
- redirect_valid  input  1  execute requests PC change (pc_sel asserted)
- redirect_pc  input  64  redirect target (ALU result)

## Operation
- FSM states: REQ (drive request), WAIT (request accepted, awaiting response), HOLD (instruction held for decode).
- Registers: pc (fetch PC), drop (1-bit discard flag), inst_q/pc_q (held instruction and its PC).
- Target alignment: next PC on redirect = {redirect_pc[63:2], 2'b00}. Sequential next PC = pc + 4, 64-bit wrap from 0xFFFF_FFFF_FFFF_FFFC to 0, no flag.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - req_ready=1 with no redirect -> WAIT.
  - Redirect in REQ, whether or not req_ready: pc <= target.
    - If req_ready=1 the same cycle: -> WAIT with drop=1.
    - Otherwise: stay in REQ. The address may change before acceptance; the memory protocol permits this.
- WAIT: imem_req_valid=0.
  - rsp_valid with drop=0 and no redirect: inst_q<=rsp_data, pc_q<=pc, -> HOLD.
  - rsp_valid with drop=1, or rsp_valid together with redirect: discard the data, clear drop, pc <= target if redirect, -> REQ.
  - Redirect without rsp_valid: drop<=1, pc<=target, stay in WAIT.
- HOLD: inst_valid=1, inst_o=inst_q, pc_o=pc_q.
  - inst_ready=1, no redirect: pc<=pc+4, -> REQ.
  - inst_ready=1 with redirect: the instruction counts as delivered; pc<=target, -> REQ.
  - Redirect without inst_ready: the held instruction is dropped; pc<=target, -> REQ.
  - Otherwise stay in HOLD; inst_o/pc_o stay stable.
- Only one request is outstanding at a time; no prefetch.

## Timing
- Reset (rst=1 at an edge): state=REQ, pc=RESET_PC, drop=0, inst_q=0, pc_q=0. Outputs after reset: inst_valid=0, inst_o=0, pc_o=0, imem_req_valid=1 from the first cycle rst is low, with imem_req_addr=RESET_PC.
- rst asserted mid-operation (any state, including an outstanding request): returns to the reset state at the next edge. A response arriving afterwards for the pre-reset request is ignored only if drop would be set. The bench must keep memory idle across reset; the IFU does not track it.
- Latency with req_ready=1 and response 1 cycle after acceptance: request in cycle N, inst_valid in cycle N+2. With inst_ready=1, the next request is in cycle N+3, giving a throughput of one instruction per 3 cycles.
- inst_valid is registered and does not depend on inst_ready or redirect_valid in the same cycle. imem_req_valid depends only on state.
- Redirect takes effect at the next edge. The first request to the target address appears the next cycle when in REQ or HOLD. From WAIT it appears the cycle after the stale response.

## Test plan
- Reset/sequential: RESET_PC default; memory returns 0x00000013 with 1-cycle latency; inst_ready=1 -> pc_o sequence 0x80000000, 0x80000004, 0x80000008 at cycles 2, 5, 8 after reset release.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_o/pc_o stable, no imem_req_valid. On inst_ready=1 -> next request at pc_o+4.
- Redirect in WAIT: redirect_pc=0x80001003 while waiting; response arrives 3 cycles later -> data discarded, inst_valid stays 0, next request addr 0x80001000.
- Redirect with consumption: in HOLD, inst_ready=1 and redirect_valid=1 with target 0x80000100 -> exactly one handshake, next request addr 0x80000100.
- Redirect with rsp_valid in the same cycle in WAIT: response discarded, next request addr = target. Also cover req_ready held low 4 cycles in REQ -> imem_req_addr stable while no redirect.
- Mid-operation reset: rst=1 in WAIT -> next cycle state REQ, addr 0x80000000, inst_valid=0. Also cover PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request addr 0.

Source files
------------

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and hands each
// instruction to decode over valid/ready, applying redirects from execute.
module ysyx_22040759_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_r, state_s;
    logic [63:0] pc_r, pc_s;
    logic        drop_r, drop_s;
    logic [31:0] inst_q_r, inst_q_s;
    logic [63:0] pc_q_r, pc_q_s;
    logic        req_valid_r;
    logic        inst_valid_r;
    logic [63:0] target_s;
    logic [63:0] pc_inc_s;

    assign target_s = {redirect_pc[63:2], 2'b00};
    assign pc_inc_s = pc_r + 64'd4;

    // Next-state logic; drop marks an in-flight response that must be discarded.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        drop_s   = drop_r;
        inst_q_s = inst_q_r;
        pc_q_s   = pc_q_r;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_s = target_s;
                    if (imem_req_ready) begin
                        state_s = ST_WAIT;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (imem_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_r || redirect_valid) begin
                        drop_s  = 1'b0;
                        state_s = ST_REQ;
                        if (redirect_valid) begin
                            pc_s = target_s;
                        end else begin
                            pc_s = pc_r;
                        end
                    end else begin
                        inst_q_s = imem_rsp_data;
                        pc_q_s   = pc_r;
                        state_s  = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_s = 1'b1;
                    pc_s   = target_s;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // A redirect wins over sequential advance whether or not decode took the instruction.
                if (redirect_valid) begin
                    pc_s    = target_s;
                    state_s = ST_REQ;
                end else if (inst_ready) begin
                    pc_s    = pc_inc_s;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_REQ;
                drop_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            inst_q_r     <= 32'd0;
            pc_q_r       <= 64'd0;
            req_valid_r  <= 1'b1;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            drop_r       <= drop_s;
            inst_q_r     <= inst_q_s;
            pc_q_r       <= pc_q_s;
            req_valid_r  <= (state_s == ST_REQ);
            inst_valid_r <= (state_s == ST_HOLD);
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = {pc_r[63:2], 2'b00};
    assign inst_valid     = inst_valid_r;
    assign inst_o         = inst_q_r;
    assign pc_o           = pc_q_r;

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Directed bench for the fetch unit: a memory model answers fetches, a scoreboard
// checks every accepted request address and every instruction handed to decode.
module tb_ysyx_22040759_ifu;
    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_rsp_valid;
    logic        w_inst_valid;
    logic [31:0] w_inst_o;
    logic [63:0] w_pc_o;
    logic        w_acc;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int hs_before = 0;
    int mem_lat = 1;

    logic [63:0] exp_req_q[$];
    logic [63:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    ysyx_22040759_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ysyx_22040759_ifu #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(32'h0000_0013), .inst_valid(w_inst_valid),
        .inst_ready(1'b1), .inst_o(w_inst_o), .pc_o(w_pc_o),
        .redirect_valid(1'b0), .redirect_pc(64'd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return {addr[21:2], 12'h013};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input int budget, input string name);
        int n;
        n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: inst_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic push_inst(input logic [63:0] pc, input logic [31:0] inst);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst);
    endtask

    // Memory model: one response mem_lat cycles after each accepted request.
    initial begin
        logic        pend;
        int          pend_cnt;
        logic [63:0] pend_addr;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = 64'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend = 1'b1;
                pend_cnt = mem_lat;
                pend_addr = imem_req_addr;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // Single-cycle-latency memory for the wrap-around instance.
    initial begin
        w_rsp_valid = 1'b0;
        w_acc = 1'b0;
        forever begin
            @(negedge clk);
            w_acc = w_req_valid && !rst;
            @(posedge clk);
            #1;
            w_rsp_valid = w_acc;
        end
    end

    // Scoreboard monitor: pops expectations on every request and decode handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
                end else begin
                    check("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
            end
            if (!rst && inst_valid && inst_ready) begin
                hs_count++;
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: got pc %h inst %h expected none", pc_o, inst_o);
                end else begin
                    check("inst_pc", pc_o, exp_pc_q.pop_front());
                    check("inst_word", {32'd0, inst_o}, {32'd0, exp_inst_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        mem_lat = 1;

        exp_req_q = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C,
                      64'h8000_0010, 64'h8000_1000, 64'h8000_0100, 64'h8000_0104,
                      64'h8000_0200, 64'h8000_0300, 64'h8000_0304, 64'h8000_0000};
        push_inst(64'h8000_0000, 32'h0000_0013);
        push_inst(64'h8000_0004, 32'h0000_1013);
        push_inst(64'h8000_0008, 32'h0000_2013);
        push_inst(64'h8000_000C, 32'h0000_3013);
        push_inst(64'h8000_1000, 32'h0040_0013);
        push_inst(64'h8000_0100, 32'h0004_0013);
        push_inst(64'h8000_0200, 32'h0008_0013);
        push_inst(64'h8000_0300, 32'h000C_0013);
        push_inst(64'h8000_0000, 32'h0000_0013);

        tick();
        tick();
        @(negedge clk);
        check("rst_inst_valid", inst_valid, 64'd0);
        check("rst_inst_o", inst_o, 64'd0);
        check("rst_pc_o", pc_o, 64'd0);
        check("rst_req_valid", imem_req_valid, 64'd1);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);

        // Sequential fetch: instructions at cycles 2, 5, 8 after release.
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("c0_req_valid", imem_req_valid, 64'd1);
        check("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        @(negedge clk);
        check("c1_no_inst", inst_valid, 64'd0);
        tick();
        @(negedge clk);
        check("c2_inst_valid", inst_valid, 64'd1);
        check("c2_pc_o", pc_o, 64'h8000_0000);
        tick();
        @(negedge clk);
        check("wrap_second_valid", w_req_valid, 64'd1);
        check("wrap_second_addr", w_req_addr, 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("c5_inst_valid", inst_valid, 64'd1);
        check("c5_pc_o", pc_o, 64'h8000_0004);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("c8_inst_valid", inst_valid, 64'd1);
        check("c8_pc_o", pc_o, 64'h8000_0008);

        // Backpressure: five stalled cycles in HOLD.
        tick();
        inst_ready = 1'b0;
        wait_inst(10, "bp_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_inst_valid", inst_valid, 64'd1);
            check("bp_pc_stable", pc_o, 64'h8000_000C);
            check("bp_inst_stable", {32'd0, inst_o}, 64'h0000_3013);
            check("bp_no_req", imem_req_valid, 64'd0);
            tick();
        end
        inst_ready = 1'b1;
        mem_lat = 3;
        tick();
        @(negedge clk);
        check("bp_next_addr", imem_req_addr, 64'h8000_0010);

        // Redirect while waiting; response arrives three cycles after acceptance.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1003;
        @(negedge clk);
        check("rw_no_inst_a", inst_valid, 64'd0);
        tick();
        redirect_valid = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        check("rw_still_wait", imem_req_valid, 64'd0);
        tick();
        @(negedge clk);
        check("rw_no_inst_b", inst_valid, 64'd0);
        tick();
        @(negedge clk);
        check("rw_no_inst_c", inst_valid, 64'd0);
        check("rw_req_valid", imem_req_valid, 64'd1);
        check("rw_target_addr", imem_req_addr, 64'h8000_1000);

        // Redirect together with consumption in HOLD.
        wait_inst(10, "rc_wait");
        hs_before = hs_count;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rc_one_handshake", hs_count, hs_before + 1);
        check("rc_inst_valid_low", inst_valid, 64'd0);
        check("rc_target_addr", imem_req_addr, 64'h8000_0100);

        // Request held off four cycles, then redirect coincident with the response.
        wait_inst(10, "rr_wait");
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req_valid", imem_req_valid, 64'd1);
            check("stall_addr_stable", imem_req_addr, 64'h8000_0104);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        @(negedge clk);
        check("rr_in_wait", imem_req_valid, 64'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rr_no_inst", inst_valid, 64'd0);
        check("rr_target_addr", imem_req_addr, 64'h8000_0200);

        // Redirect in REQ while the request is not accepted.
        wait_inst(10, "rq_wait");
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0302;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("rq_target_addr", imem_req_addr, 64'h8000_0300);

        // Reset with a request outstanding.
        wait_inst(10, "mr_wait");
        mem_lat = 3;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        check("mr_req_valid", imem_req_valid, 64'd1);
        check("mr_req_addr", imem_req_addr, 64'h8000_0000);
        check("mr_inst_valid", inst_valid, 64'd0);
        wait_inst(10, "mr_inst");
        imem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("sb_req_drained", exp_req_q.size(), 64'd0);
        check("sb_inst_drained", exp_pc_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
